// File: rtl/digi_pkg.sv
// Shared constants for the 7-segment display path: segment codes, digi[] field
// positions and control-byte layout.
package digi_pkg;

  localparam int DIGI_AN_MSB = 11;
  localparam int DIGI_AN_LSB = 8;
  localparam int DIGI_DP     = 7;

  localparam int EN_LSB = 0;
  localparam int DP_LSB = 4;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    DIG0 = 2'd0,
    DIG1 = 2'd1,
    DIG2 = 2'd2,
    DIG3 = 2'd3
  } digit_e;

endpackage

// File: rtl/hex7seg_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern.
module hex7seg_decoder
  import digi_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = HEX_SEG[i_nibble];

endmodule

// File: rtl/digi_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller; value/control writes are
// double-buffered and only take effect at the digit-3 -> digit-0 wrap.
module digi_scan_ctrl
  import digi_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4,
  parameter int DIV_W     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_val_we,
  input  logic [15:0] i_val_wdata,
  input  logic        i_ctl_we,
  input  logic [7:0]  i_ctl_wdata,
  output logic [11:0] o_digi,
  output logic        o_frame_done,
  output logic        o_pending
);

  logic [DIV_W-1:0] r_cnt;
  digit_e           r_idx;
  digit_e           w_idx_next;
  logic             w_tick;
  logic             w_boundary;
  logic [1:0]       w_idx;

  logic [15:0] r_pend_val;
  logic [7:0]  r_pend_ctl;
  logic        r_pending;
  logic [15:0] r_shadow_val;
  logic [7:0]  r_shadow_ctl;
  logic        r_frame_done;
  logic [11:0] r_digi;

  logic [3:0]  w_nibble;
  logic [6:0]  w_seg_n;
  logic [3:0]  w_en;
  logic [3:0]  w_dp;
  logic        w_blank;
  logic [11:0] w_digi_next;

  assign w_tick     = (r_cnt == DIV_W'(SCAN_DIV - 1));
  assign w_boundary = w_tick && (r_idx == DIG3);
  assign w_idx      = r_idx;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx <= DIG0;
    end else begin
      r_idx <= w_idx_next;
    end
  end

  always_comb begin
    w_idx_next = r_idx;
    if (w_tick) begin
      case (r_idx)
        DIG0:    w_idx_next = DIG1;
        DIG1:    w_idx_next = DIG2;
        DIG2:    w_idx_next = DIG3;
        default: w_idx_next = DIG0;
      endcase
    end
  end

  // Shadow takes the pre-edge pending contents, so a write landing on the
  // boundary edge is held over to the following frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_val   <= '0;
      r_pend_ctl   <= '0;
      r_pending    <= 1'b0;
      r_shadow_val <= '0;
      r_shadow_ctl <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (w_boundary && r_pending) begin
        r_shadow_val <= r_pend_val;
        r_shadow_ctl <= r_pend_ctl;
      end
      if (i_val_we) begin
        r_pend_val <= i_val_wdata;
      end
      if (i_ctl_we) begin
        r_pend_ctl <= i_ctl_wdata;
      end
      if (i_val_we || i_ctl_we) begin
        r_pending <= 1'b1;
      end else if (w_boundary) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_nibble = r_shadow_val[{w_idx, 2'b00} +: 4];
  assign w_en     = r_shadow_ctl[EN_LSB +: 4];
  assign w_dp     = r_shadow_ctl[DP_LSB +: 4];
  assign w_blank  = (r_cnt < DIV_W'(BLANK_CYC)) || !w_en[w_idx];

  hex7seg_decoder u_dec (
    .i_nibble (w_nibble),
    .o_seg_n  (w_seg_n)
  );

  always_comb begin
    w_digi_next                          = '1;
    w_digi_next[DIGI_AN_MSB:DIGI_AN_LSB] = w_blank ? 4'hF : ~(4'b0001 << w_idx);
    w_digi_next[DIGI_DP]                 = ~w_dp[w_idx];
    w_digi_next[6:0]                     = w_seg_n;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digi <= 12'hFFF;
    end else begin
      r_digi <= w_digi_next;
    end
  end

  assign o_digi       = r_digi;
  assign o_frame_done = r_frame_done;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_digi_scan_ctrl.sv
// Bench for digi_scan_ctrl: cycle-indexed reference model plus directed and
// randomized write scenarios.
module tb_digi_scan_ctrl;

  localparam int SD    = 8;
  localparam int BC    = 2;
  localparam int FRAME = 4 * SD;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        val_we    = 1'b0;
  logic [15:0] val_wdata = '0;
  logic        ctl_we    = 1'b0;
  logic [7:0]  ctl_wdata = '0;
  logic [11:0] digi;
  logic        frame_done;
  logic        pending;

  int total = 0;
  int bad   = 0;

  // Reference model: slot position and digit follow directly from the number
  // of edges since reset release.
  int          m_k      = 0;
  logic [15:0] m_pv     = '0;
  logic [15:0] m_sv     = '0;
  logic [7:0]  m_pc     = '0;
  logic [7:0]  m_sc     = '0;
  logic        m_pend   = 1'b0;
  logic [11:0] exp_digi = 12'hFFF;
  logic        exp_fd   = 1'b0;
  logic        exp_pend = 1'b0;
  int          m_pos;
  int          m_dig;
  logic [3:0]  m_an;

  always #5 clk = ~clk;

  digi_scan_ctrl #(
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC),
    .DIV_W     (16)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_val_we     (val_we),
    .i_val_wdata  (val_wdata),
    .i_ctl_we     (ctl_we),
    .i_ctl_wdata  (ctl_wdata),
    .o_digi       (digi),
    .o_frame_done (frame_done),
    .o_pending    (pending)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_pv = '0; m_sv = '0; m_pc = '0; m_sc = '0; m_pend = 1'b0;
      exp_digi = 12'hFFF; exp_fd = 1'b0; exp_pend = 1'b0;
    end else begin
      m_pos = m_k % SD;
      m_dig = (m_k / SD) % 4;
      m_an  = (m_pos < BC || !m_sc[m_dig]) ? 4'hF : ~(4'b0001 << m_dig);
      exp_digi = {m_an, ~m_sc[4 + m_dig], seg_of(m_sv[4*m_dig +: 4])};
      m_k = m_k + 1;
      exp_fd = (m_k % FRAME == 0);
      if (exp_fd && m_pend) begin
        m_sv = m_pv; m_sc = m_pc; m_pend = 1'b0;
      end
      if (val_we) begin m_pv = val_wdata; m_pend = 1'b1; end
      if (ctl_we) begin m_pc = ctl_wdata; m_pend = 1'b1; end
      exp_pend = m_pend;
    end
  end

  // One clock: drive inputs at the falling edge, return just after the rising edge.
  task automatic tick(input logic vw, input logic [15:0] vd, input logic cw, input logic [7:0] cd);
    @(negedge clk);
    val_we = vw; val_wdata = vd; ctl_we = cw; ctl_wdata = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(1'b0, 16'h0, 1'b0, 8'h0);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) idle();
    total++;
    if ({digi, frame_done, pending} !== {12'hFFF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_hold digi=%h fd=%b pend=%b expected FFF 0 0", digi, frame_done, pending);
    end
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL reset_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      if (frame_done === 1'b1) n = i;
    end
    total++;
    if (n != FRAME) begin
      bad++; $display("FAIL first_frame cycles=%0d expected %0d", n, FRAME);
    end
    tick(1'b1, 16'hBEEF, 1'b1, 8'hFF);
    repeat (9) idle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({digi, frame_done, pending} !== {12'hFFF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset digi=%h fd=%b pend=%b expected FFF 0 0", digi, frame_done, pending);
    end
    idle(); idle();
    rst_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL rerelease_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      if (frame_done === 1'b1) n = i;
    end
    total++;
    if (n != FRAME || pending !== 1'b0 || digi[11:8] !== 4'hF) begin
      bad++; $display("FAIL reset_discard cycles=%0d pend=%b an=%h expected %0d 0 F", n, pending, digi[11:8], FRAME);
    end
  endtask

  task automatic test_basic_scan();
    bit seen = 0;
    int pos, dig;
    tick(1'b1, 16'h1234, 1'b1, 8'h0F);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL basic_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      pos = (m_k - 1) % SD;
      dig = ((m_k - 1) / SD) % 4;
      if (seen && pos == 4 && (dig == 0 || dig == 3)) begin
        total++;
        if (digi !== ((dig == 0) ? 12'hE99 : 12'h7F9)) begin
          bad++; $display("FAIL basic_digit%0d digi=%h expected %h", dig, digi, (dig == 0) ? 12'hE99 : 12'h7F9);
        end
      end
      if (seen && pos < BC) begin
        total++;
        if (digi[11:8] !== 4'hF) begin
          bad++; $display("FAIL basic_blank slot=%0d an=%h expected F", pos, digi[11:8]);
        end
      end
      if (frame_done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL basic_boundary frame_done=0 expected 1 within %0d cycles", 2 * FRAME);
    end
  endtask

  task automatic test_no_tearing();
    bit hit = 0;
    int pos, dig;
    for (int i = 0; i < FRAME && m_k % FRAME != 12; i++) idle();
    tick(1'b1, 16'hABCD, 1'b0, 8'h0);
    for (int i = 0; i < FRAME && !hit; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL tear_hold k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      if (frame_done === 1'b1) hit = 1;
      else begin
        total++;
        if (pending !== 1'b1) begin
          bad++; $display("FAIL tear_pending pend=%b expected 1", pending);
        end
        if ((m_k - 1) % FRAME == 3 * SD + 4) begin
          total++;
          if (digi !== 12'h7F9) begin
            bad++; $display("FAIL tear_old digi=%h expected 7F9", digi);
          end
        end
      end
    end
    total++;
    if (!hit || pending !== 1'b0) begin
      bad++; $display("FAIL tear_commit hit=%0d pend=%b expected 1 0", hit, pending);
    end
    for (int i = 0; i < FRAME; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL tear_new k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      pos = (m_k - 1) % SD;
      dig = ((m_k - 1) / SD) % 4;
      if (i < SD && pos == 4 && dig == 0) begin
        total++;
        if (digi !== 12'hEA1) begin
          bad++; $display("FAIL tear_digit0 digi=%h expected EA1", digi);
        end
      end
    end
  endtask

  task automatic test_collision();
    int frm = 0;
    for (int i = 0; i < FRAME && m_k % FRAME != 5; i++) idle();
    tick(1'b1, 16'h9999, 1'b0, 8'h0);
    for (int i = 0; i < FRAME && m_k % FRAME != FRAME - 1; i++) idle();
    tick(1'b1, 16'h5555, 1'b0, 8'h0);
    total++;
    if (frame_done !== 1'b1 || pending !== 1'b1) begin
      bad++; $display("FAIL collide_edge fd=%b pend=%b expected 1 1", frame_done, pending);
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL collide_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      if ((m_k - 1) % FRAME == 4) begin
        total++;
        if (digi !== ((frm == 0) ? 12'hE90 : 12'hE92)) begin
          bad++; $display("FAIL collide_frame%0d digi=%h expected %h", frm, digi, (frm == 0) ? 12'hE90 : 12'hE92);
        end
      end
      if (frame_done === 1'b1) begin
        frm++;
        total++;
        if (pending !== 1'b0) begin
          bad++; $display("FAIL collide_clear pend=%b expected 0", pending);
        end
      end
    end
  endtask

  task automatic test_mask();
    bit seen = 0;
    int pos, dig;
    tick(1'b0, 16'h0, 1'b1, 8'h25);
    for (int i = 0; i < 2 * FRAME; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL mask_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      pos = (m_k - 1) % SD;
      dig = ((m_k - 1) / SD) % 4;
      if (seen && pos == 5) begin
        total++;
        if (digi[11:8] !== ((dig == 1 || dig == 3) ? 4'hF : ~(4'b0001 << dig)) ||
            digi[7] !== ((dig == 1) ? 1'b0 : 1'b1)) begin
          bad++; $display("FAIL mask_digit%0d an=%h dp_n=%b", dig, digi[11:8], digi[7]);
        end
      end
      if (frame_done === 1'b1) seen = 1;
    end
  endtask

  task automatic test_last_write();
    int last_fd = -1;
    int pulses = 0;
    for (int i = 0; i < FRAME && m_k % FRAME != 2; i++) idle();
    tick(1'b1, 16'h0001, 1'b0, 8'h0);
    idle();
    tick(1'b1, 16'h0002, 1'b0, 8'h0);
    idle();
    tick(1'b1, 16'h0003, 1'b0, 8'h0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      idle();
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL lastwr_scan k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
      if (pulses > 0 && (m_k - 1) % FRAME == 4) begin
        total++;
        if (digi !== 12'hEB0) begin
          bad++; $display("FAIL lastwr_digit0 digi=%h expected EB0", digi);
        end
      end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          total++;
          if (m_k - last_fd != FRAME) begin
            bad++; $display("FAIL fd_period cycles=%0d expected %0d", m_k - last_fd, FRAME);
          end
        end
        last_fd = m_k;
        pulses++;
      end
    end
    total++;
    if (pulses != 3) begin
      bad++; $display("FAIL fd_count pulses=%0d expected 3", pulses);
    end
  endtask

  task automatic test_random();
    logic vw, cw;
    for (int i = 0; i < 400; i++) begin
      vw = ($urandom_range(0, 11) == 0);
      cw = ($urandom_range(0, 15) == 0);
      tick(vw, 16'($urandom), cw, 8'($urandom));
      total++;
      if ({digi, frame_done, pending} !== {exp_digi, exp_fd, exp_pend}) begin
        bad++; $display("FAIL random k=%0d digi=%h fd=%b pend=%b expected %h %b %b", m_k, digi, frame_done, pending, exp_digi, exp_fd, exp_pend);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_no_tearing();
    test_collision();
    test_mask();
    test_last_write();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
